xif_offload_tracker: RTL and testbench

- Parametrised CORE-V-XIF bridge between the CPU's 3-read-port XIF and a coprocessor with X_NUM_RS (2 or 3) read ports.
- Passes the issue handshake through combinationally. Adds a per-ID outstanding-instruction scoreboard driven by issue, commit and result events.
- Adds a 2-entry registered result buffer toward the CPU.
- Caps in-flight offloads at MAX_OUTSTANDING and drops/flags protocol-violating results.

---
 rtl/xif_offload_tracker.sv | 185 ++++++++++++++++++
 tb/tb_xif_offload_tracker.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_offload_tracker.sv
// XIF offload tracker: issue pass-through, per-ID outstanding scoreboard
// and a 2-entry registered result buffer toward the CPU.
module xif_offload_tracker #(
  parameter int unsigned X_ID_WIDTH      = 4,
  parameter int unsigned X_NUM_RS        = 2,
  parameter int unsigned X_RFR_WIDTH     = 32,
  parameter int unsigned X_RFW_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            core_issue_valid_i,
  output logic                            core_issue_ready_o,
  input  logic [31:0]                     core_issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]           core_issue_id_i,
  input  logic [3*X_RFR_WIDTH-1:0]        core_issue_rs_i,
  input  logic [2:0]                      core_issue_rs_valid_i,
  output logic                            core_issue_accept_o,
  output logic                            core_issue_writeback_o,
  output logic                            cop_issue_valid_o,
  input  logic                            cop_issue_ready_i,
  output logic [31:0]                     cop_issue_instr_o,
  output logic [X_ID_WIDTH-1:0]           cop_issue_id_o,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] cop_issue_rs_o,
  output logic [X_NUM_RS-1:0]             cop_issue_rs_valid_o,
  input  logic                            cop_issue_accept_i,
  input  logic                            cop_issue_writeback_i,
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic                            commit_kill_i,
  input  logic                            cop_result_valid_i,
  output logic                            cop_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]           cop_result_id_i,
  input  logic [X_RFW_WIDTH-1:0]          cop_result_data_i,
  input  logic                            cop_result_we_i,
  output logic                            core_result_valid_o,
  input  logic                            core_result_ready_i,
  output logic [X_ID_WIDTH-1:0]           core_result_id_o,
  output logic [X_RFW_WIDTH-1:0]          core_result_data_o,
  output logic                            core_result_we_o,
  output logic [CW-1:0]                   outstanding_o,
  output logic                            err_o
);

  localparam int unsigned NE = 2 ** X_ID_WIDTH;
  localparam int unsigned RW = X_ID_WIDTH + X_RFW_WIDTH + 1;

  typedef enum logic [1:0] {
    S_FREE,
    S_ISSUED,
    S_COMMITTED
  } ent_e;

  if ((X_NUM_RS != 2) && (X_NUM_RS != 3)) begin : g_bad_rs
    $error("X_NUM_RS must be 2 or 3");
  end

  if (X_NUM_RS == 2) begin : g_rs2
    logic w_unused_rs;
    assign w_unused_rs = ^{core_issue_rs_i[3*X_RFR_WIDTH-1:2*X_RFR_WIDTH],
                           core_issue_rs_valid_i[2]};
  end

  ent_e          r_state   [NE];
  ent_e          w_state_nx[NE];
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          r_v0;
  logic          r_v1;
  logic [RW-1:0] r_head;
  logic [RW-1:0] r_tail;

  logic          w_stall;
  logic          w_alloc;
  logic          w_res_hs;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_inc;
  logic          w_dec_kill;
  logic [RW-1:0] w_res_word;

  // Issue pass-through gated by the registered count and entry state
  assign w_stall = (r_count == CW'(MAX_OUTSTANDING)) |
                   (r_state[core_issue_id_i] != S_FREE);
  assign cop_issue_valid_o      = core_issue_valid_i & ~w_stall;
  assign core_issue_ready_o     = cop_issue_ready_i & ~w_stall;
  assign cop_issue_instr_o      = core_issue_instr_i;
  assign cop_issue_id_o         = core_issue_id_i;
  assign cop_issue_rs_o         = core_issue_rs_i[X_NUM_RS*X_RFR_WIDTH-1:0];
  assign cop_issue_rs_valid_o   = core_issue_rs_valid_i[X_NUM_RS-1:0];
  assign core_issue_accept_o    = cop_issue_accept_i;
  assign core_issue_writeback_o = cop_issue_writeback_i;

  assign w_alloc = cop_issue_valid_o & cop_issue_ready_i & cop_issue_accept_i;

  assign cop_result_ready_o = ~r_v1 | core_result_ready_i;
  assign w_res_hs = cop_result_valid_i & cop_result_ready_o;
  assign w_push   = w_res_hs & (r_state[cop_result_id_i] == S_COMMITTED);
  assign w_drop   = w_res_hs & ~w_push;
  assign w_pop    = r_v0 & core_result_ready_i;
  assign w_res_word = {cop_result_id_i, cop_result_data_i, cop_result_we_i};

  // A kill landing on the entry being allocated cancels the allocation
  assign w_inc = w_alloc & ~(commit_valid_i & commit_kill_i &
                             (commit_id_i == core_issue_id_i));
  assign w_dec_kill = commit_valid_i & commit_kill_i &
                      (r_state[commit_id_i] == S_ISSUED);

  // Per-ID entry next state from issue, commit and result events
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      w_state_nx[i] = r_state[i];
    end
    if (w_alloc) begin
      w_state_nx[core_issue_id_i] = S_ISSUED;
    end
    if (commit_valid_i && (w_state_nx[commit_id_i] == S_ISSUED)) begin
      w_state_nx[commit_id_i] = commit_kill_i ? S_FREE : S_COMMITTED;
    end
    if (w_push) begin
      w_state_nx[cop_result_id_i] = S_FREE;
    end
  end

  // Scoreboard state, outstanding count and drop pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NE; i++) begin
        r_state[i] <= S_FREE;
      end
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        r_state[i] <= w_state_nx[i];
      end
      r_count <= r_count + CW'(w_inc) - CW'(w_dec_kill) - CW'(w_push);
      r_err   <= w_drop;
    end
  end

  // Two-entry result buffer; head register drives the CPU directly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      unique case (1'b1)
        w_push & w_pop: begin
          if (r_v1) begin
            r_head <= r_tail;
            r_tail <= w_res_word;
          end else begin
            r_head <= w_res_word;
          end
        end
        w_push & ~w_pop: begin
          if (r_v0) begin
            r_tail <= w_res_word;
            r_v1   <= 1'b1;
          end else begin
            r_head <= w_res_word;
            r_v0   <= 1'b1;
          end
        end
        ~w_push & w_pop: begin
          r_head <= r_tail;
          r_v0   <= r_v1;
          r_v1   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign core_result_valid_o = r_v0;
  assign {core_result_id_o, core_result_data_o, core_result_we_o} = r_head;
  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: tb/tb_xif_offload_tracker.sv
// Directed bench for xif_offload_tracker (X_NUM_RS=2, MAX_OUTSTANDING=4).
module tb_xif_offload_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_issue_valid_i;
  logic        core_issue_ready_o;
  logic [31:0] core_issue_instr_i;
  logic [3:0]  core_issue_id_i;
  logic [95:0] core_issue_rs_i;
  logic [2:0]  core_issue_rs_valid_i;
  logic        core_issue_accept_o;
  logic        core_issue_writeback_o;
  logic        cop_issue_valid_o;
  logic        cop_issue_ready_i;
  logic [31:0] cop_issue_instr_o;
  logic [3:0]  cop_issue_id_o;
  logic [63:0] cop_issue_rs_o;
  logic [1:0]  cop_issue_rs_valid_o;
  logic        cop_issue_accept_i;
  logic        cop_issue_writeback_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        cop_result_valid_i;
  logic        cop_result_ready_o;
  logic [3:0]  cop_result_id_i;
  logic [31:0] cop_result_data_i;
  logic        cop_result_we_i;
  logic        core_result_valid_o;
  logic        core_result_ready_i;
  logic [3:0]  core_result_id_o;
  logic [31:0] core_result_data_o;
  logic        core_result_we_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xif_offload_tracker #(
    .X_ID_WIDTH(4), .X_NUM_RS(2), .X_RFR_WIDTH(32),
    .X_RFW_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_issue_valid_i(core_issue_valid_i),
    .core_issue_ready_o(core_issue_ready_o),
    .core_issue_instr_i(core_issue_instr_i),
    .core_issue_id_i(core_issue_id_i),
    .core_issue_rs_i(core_issue_rs_i),
    .core_issue_rs_valid_i(core_issue_rs_valid_i),
    .core_issue_accept_o(core_issue_accept_o),
    .core_issue_writeback_o(core_issue_writeback_o),
    .cop_issue_valid_o(cop_issue_valid_o),
    .cop_issue_ready_i(cop_issue_ready_i),
    .cop_issue_instr_o(cop_issue_instr_o),
    .cop_issue_id_o(cop_issue_id_o),
    .cop_issue_rs_o(cop_issue_rs_o),
    .cop_issue_rs_valid_o(cop_issue_rs_valid_o),
    .cop_issue_accept_i(cop_issue_accept_i),
    .cop_issue_writeback_i(cop_issue_writeback_i),
    .commit_valid_i(commit_valid_i),
    .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .cop_result_valid_i(cop_result_valid_i),
    .cop_result_ready_o(cop_result_ready_o),
    .cop_result_id_i(cop_result_id_i),
    .cop_result_data_i(cop_result_data_i),
    .cop_result_we_i(cop_result_we_i),
    .core_result_valid_o(core_result_valid_o),
    .core_result_ready_i(core_result_ready_i),
    .core_result_id_o(core_result_id_o),
    .core_result_data_o(core_result_data_o),
    .core_result_we_o(core_result_we_o),
    .outstanding_o(outstanding_o),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    core_issue_valid_i    = 1'b0;
    core_issue_instr_i    = 32'h0000_0000;
    core_issue_id_i       = 4'd0;
    core_issue_rs_i       = '0;
    core_issue_rs_valid_i = 3'b000;
    cop_issue_ready_i     = 1'b1;
    cop_issue_accept_i    = 1'b1;
    cop_issue_writeback_i = 1'b0;
    commit_valid_i        = 1'b0;
    commit_id_i           = 4'd0;
    commit_kill_i         = 1'b0;
    cop_result_valid_i    = 1'b0;
    cop_result_id_i       = 4'd0;
    cop_result_data_i     = 32'h0;
    cop_result_we_i       = 1'b0;
    core_result_ready_i   = 1'b1;

    // reset state
    #12;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_res_valid", core_result_valid_o, 0);
    chk("rst_res_id", core_result_id_o, 0);
    chk("rst_res_data", core_result_data_o, 0);
    chk("rst_res_we", core_result_we_o, 0);
    chk("rst_res_ready", cop_result_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // operand forwarding and pass-through
    core_issue_rs_i       = {32'h3, 32'h2, 32'h1};
    core_issue_rs_valid_i = 3'b111;
    core_issue_instr_i    = 32'hCAFE_0001;
    core_issue_id_i       = 4'd9;
    cop_issue_writeback_i = 1'b1;
    settle();
    chk("rs_fwd", cop_issue_rs_o, 64'h0000_0002_0000_0001);
    chk("rs_valid_fwd", cop_issue_rs_valid_o, 2'b11);
    chk("instr_fwd", cop_issue_instr_o, 32'hCAFE_0001);
    chk("id_fwd", cop_issue_id_o, 9);
    chk("accept_fwd", core_issue_accept_o, 1);
    chk("wb_fwd", core_issue_writeback_o, 1);
    chk("idle_cop_valid", cop_issue_valid_o, 0);
    cop_issue_writeback_i = 1'b0;

    // fill to MAX_OUTSTANDING with IDs 0..3
    core_issue_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_issue_id_i = 4'(i);
      settle();
      chk("fill_ready", core_issue_ready_o, 1);
      chk("fill_valid", cop_issue_valid_o, 1);
      tick();
    end
    core_issue_id_i = 4'd4;
    settle();
    chk("full_ready", core_issue_ready_o, 0);
    chk("full_valid", cop_issue_valid_o, 0);
    chk("full_count", outstanding_o, 4);

    // same-cycle free does not unblock issue
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd0;
    commit_kill_i  = 1'b1;
    settle();
    chk("free_same_cyc", core_issue_ready_o, 0);
    tick();
    commit_valid_i = 1'b0;
    settle();
    chk("free_next_cyc", core_issue_ready_o, 1);
    chk("count_after_kill", outstanding_o, 3);
    tick();
    core_issue_valid_i = 1'b0;
    chk("count_refill", outstanding_o, 4);

    // kill everything still in flight
    commit_valid_i = 1'b1;
    commit_kill_i  = 1'b1;
    for (int i = 1; i < 5; i++) begin
      commit_id_i = 4'(i);
      tick();
    end
    commit_valid_i = 1'b0;
    chk("count_drained", outstanding_o, 0);

    // duplicate ID is held until its entry frees
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = 4'd1;
    tick();
    settle();
    chk("dup_valid_issued", cop_issue_valid_o, 0);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd1;
    commit_kill_i  = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    chk("dup_valid_commit", cop_issue_valid_o, 0);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd1;
    cop_result_data_i  = 32'h0000_0011;
    cop_result_we_i    = 1'b1;
    tick();
    cop_result_valid_i = 1'b0;
    chk("r1_valid", core_result_valid_o, 1);
    chk("r1_id", core_result_id_o, 1);
    chk("r1_data", core_result_data_o, 32'h11);
    chk("r1_we", core_result_we_o, 1);
    chk("r1_count", outstanding_o, 0);
    chk("dup_valid_freed", cop_issue_valid_o, 1);
    cop_issue_accept_i = 1'b0;
    tick();
    core_issue_valid_i = 1'b0;
    cop_issue_accept_i = 1'b1;
    chk("noaccept_count", outstanding_o, 0);
    chk("r1_popped", core_result_valid_o, 0);

    // commit then result for ID 2
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = 4'd2;
    tick();
    core_issue_valid_i = 1'b0;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd2;
    commit_kill_i  = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    chk("id2_count", outstanding_o, 1);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd2;
    cop_result_data_i  = 32'hDEAD_BEEF;
    cop_result_we_i    = 1'b1;
    tick();
    cop_result_valid_i = 1'b0;
    chk("id2_valid", core_result_valid_o, 1);
    chk("id2_id", core_result_id_o, 2);
    chk("id2_data", core_result_data_o, 32'hDEAD_BEEF);
    chk("id2_count0", outstanding_o, 0);
    chk("id2_err", err_o, 0);
    tick();

    // same-cycle issue and commit goes straight to COMMITTED
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = 4'd3;
    commit_valid_i     = 1'b1;
    commit_id_i        = 4'd3;
    commit_kill_i      = 1'b0;
    tick();
    core_issue_valid_i = 1'b0;
    commit_valid_i     = 1'b0;
    chk("id3_count", outstanding_o, 1);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd3;
    cop_result_data_i  = 32'h3333_3333;
    cop_result_we_i    = 1'b0;
    tick();
    cop_result_valid_i = 1'b0;
    chk("id3_valid", core_result_valid_o, 1);
    chk("id3_data", core_result_data_o, 32'h3333_3333);
    chk("id3_count0", outstanding_o, 0);
    tick();

    // killed ID: result is dropped with an error pulse
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = 4'd5;
    tick();
    core_issue_valid_i = 1'b0;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd5;
    commit_kill_i  = 1'b1;
    tick();
    commit_valid_i = 1'b0;
    chk("id5_count", outstanding_o, 0);
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd5;
    cop_result_data_i  = 32'h5555_5555;
    settle();
    chk("id5_ready", cop_result_ready_o, 1);
    tick();
    cop_result_valid_i = 1'b0;
    chk("id5_err", err_o, 1);
    chk("id5_novalid", core_result_valid_o, 0);
    tick();
    chk("id5_err_clr", err_o, 0);
    chk("id5_novalid2", core_result_valid_o, 0);

    // backpressure: 3 committed results, 2 buffered
    core_result_ready_i = 1'b0;
    core_issue_valid_i  = 1'b1;
    commit_valid_i      = 1'b1;
    commit_kill_i       = 1'b0;
    for (int i = 6; i < 9; i++) begin
      core_issue_id_i = 4'(i);
      commit_id_i     = 4'(i);
      tick();
    end
    core_issue_valid_i = 1'b0;
    commit_valid_i     = 1'b0;
    chk("bp_count3", outstanding_o, 3);
    cop_result_valid_i = 1'b1;
    cop_result_we_i    = 1'b1;
    for (int i = 6; i < 9; i++) begin
      cop_result_id_i   = 4'(i);
      cop_result_data_i = 32'hA000_0000 | 32'(i);
      tick();
    end
    chk("bp_full_ready", cop_result_ready_o, 0);
    chk("bp_head_valid", core_result_valid_o, 1);
    chk("bp_head_id", core_result_id_o, 6);
    chk("bp_count1", outstanding_o, 1);
    core_result_ready_i = 1'b1;
    settle();
    chk("bp_ready_thru", cop_result_ready_o, 1);
    tick();
    cop_result_valid_i = 1'b0;
    chk("drain_7_valid", core_result_valid_o, 1);
    chk("drain_7_id", core_result_id_o, 7);
    chk("drain_7_data", core_result_data_o, 32'hA000_0007);
    tick();
    chk("drain_8_valid", core_result_valid_o, 1);
    chk("drain_8_id", core_result_id_o, 8);
    chk("drain_8_count", outstanding_o, 0);
    tick();
    chk("drain_empty", core_result_valid_o, 0);

    // reset mid-operation clears state immediately
    core_issue_valid_i = 1'b1;
    core_issue_id_i    = 4'd9;
    commit_valid_i     = 1'b1;
    commit_id_i        = 4'd9;
    core_result_ready_i = 1'b0;
    tick();
    core_issue_valid_i = 1'b0;
    commit_valid_i     = 1'b0;
    cop_result_valid_i = 1'b1;
    cop_result_id_i    = 4'd9;
    cop_result_data_i  = 32'h9999_9999;
    tick();
    cop_result_valid_i = 1'b0;
    chk("pre_rst_valid", core_result_valid_o, 1);
    rst_n = 1'b0;
    settle();
    chk("mid_rst_valid", core_result_valid_o, 0);
    chk("mid_rst_count", outstanding_o, 0);
    chk("mid_rst_data", core_result_data_o, 0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
